// File: rtl/fetch_queue.sv
// Instruction fetch queue: pipelined in-order bus reads feeding a DEPTH-entry
// FIFO of {word, address, error}, with jump flush and stale-response dropping.
module fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_ADDR      = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                ib_addr,
    output logic                       ib_req,
    input  logic                       ib_req_ready,
    input  logic                       ib_rsp_valid,
    input  logic [31:0]                ib_rsp_data,
    input  logic                       ib_rsp_err,
    output logic [31:0]                instr,
    output logic [31:0]                instr_addr,
    output logic                       instr_err,
    output logic                       valid,
    input  logic                       ready,
    input  logic                       jmp,
    input  logic [31:0]                jmp_addr,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = LW + 1;

    logic [31:0]   pc;
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [OW-1:0] pending;
    logic [OW-1:0] drop;
    logic          halted;

    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   addr_mem [DEPTH];
    logic          err_mem  [DEPTH];

    logic [31:0]   tag_mem  [MAX_OUTSTANDING];
    logic [TW-1:0] tag_wp;
    logic [TW-1:0] tag_rp;

    logic          accept;
    logic          rsp_live;
    logic          consume;
    logic [CW-1:0] in_use;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slots already claimed: held words plus live (non-dropped) requests in flight.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        in_use   = CW'(level) + CW'(pending) - CW'(drop);
        ib_req   = !rst && !jmp && !halted
                   && (pending < OW'(MAX_OUTSTANDING))
                   && (in_use < CW'(DEPTH));
        accept   = ib_req && ib_req_ready;
        rsp_live = ib_rsp_valid && !jmp && (drop == '0);
        consume  = valid && ready && !jmp;
    end

    assign ib_addr    = pc;
    assign valid      = (level != '0);
    assign instr      = data_mem[rp];
    assign instr_addr = addr_mem[rp];
    assign instr_err  = err_mem[rp];

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_ADDR;
            wp      <= '0;
            rp      <= '0;
            level   <= '0;
            pending <= '0;
            drop    <= '0;
            halted  <= 1'b0;
            tag_wp  <= '0;
            tag_rp  <= '0;
        end else begin
            pending <= pending + OW'(accept) - OW'(ib_rsp_valid);
            if (accept) begin
                pc     <= pc + 32'd4;
                tag_wp <= tag_next(tag_wp);
            end
            if (ib_rsp_valid) begin
                tag_rp <= tag_next(tag_rp);
            end

            if (jmp) begin
                // Every request still unanswered after this cycle belongs to the old stream.
                pc     <= jmp_addr & ~32'h3;
                rp     <= wp;
                level  <= '0;
                halted <= 1'b0;
                drop   <= pending - OW'(ib_rsp_valid);
            end else begin
                if (ib_rsp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (rsp_live) begin
                    wp <= wp + 1'b1;
                    if (ib_rsp_err) begin
                        halted <= 1'b1;
                    end
                end
                if (consume) begin
                    rp <= rp + 1'b1;
                end
                case ({rsp_live, consume})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

    // NOTE: storage arrays carry no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wp] <= pc;
        end
        if (rsp_live) begin
            data_mem[wp] <= ib_rsp_data;
            addr_mem[wp] <= tag_mem[tag_rp];
            err_mem[wp]  <= ib_rsp_err;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order bus model with random latency, epoch-based
// reference of the delivered instruction stream, scoreboard checked at decode.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RST_A = 32'h0;

    logic        clk;
    logic        rst;
    logic [31:0] ib_addr;
    logic        ib_req;
    logic        ib_req_ready;
    logic        ib_rsp_valid;
    logic [31:0] ib_rsp_data;
    logic        ib_rsp_err;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        instr_err;
    logic        valid;
    logic        ready;
    logic        jmp;
    logic [31:0] jmp_addr;
    logic [2:0]  level;

    fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_ADDR(RST_A)) dut (
        .clk(clk), .rst(rst), .ib_addr(ib_addr), .ib_req(ib_req),
        .ib_req_ready(ib_req_ready), .ib_rsp_valid(ib_rsp_valid),
        .ib_rsp_data(ib_rsp_data), .ib_rsp_err(ib_rsp_err), .instr(instr),
        .instr_addr(instr_addr), .instr_err(instr_err), .valid(valid),
        .ready(ready), .jmp(jmp), .jmp_addr(jmp_addr), .level(level)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          epoch;
        int          due;
    } bus_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } ent_t;

    bus_t        bq[$];
    ent_t        sb[$];
    logic [31:0] cons_addr[$];
    logic        cons_err[$];

    int          cyc = 0;
    int          epoch = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          n_cons = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          err_rand = 0;
    bit          err_addr_en = 0;
    logic [31:0] err_addr = 32'h0;
    logic [31:0] exp_pc = RST_A;
    bit          halted_m = 0;

    int          live;
    bit          exp_req;
    ent_t        e;
    bus_t        b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] log_addr(input int i);
        return (i < cons_addr.size()) ? cons_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic log_err(input int i);
        return (i < cons_err.size()) ? cons_err[i] : 1'bx;
    endfunction

    // Bus responder: in order, one per cycle, once the head's latency has elapsed.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst && bq.size() != 0 && bq[0].due <= cyc) begin
            ib_rsp_valid = 1'b1;
            ib_rsp_data  = bq[0].data;
            ib_rsp_err   = bq[0].err;
        end else begin
            ib_rsp_valid = 1'b0;
            ib_rsp_data  = $urandom;
            ib_rsp_err   = 1'($urandom);
        end
    end

    // Reference model and scoreboard monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            live = 0;
            foreach (bq[i]) if (bq[i].epoch == epoch) live++;
            exp_req = !jmp && !halted_m && (bq.size() < MAXO) && (sb.size() + live < DEPTH);
            check("valid", 32'(valid), 32'(sb.size() != 0));
            check("level", 32'(level), 32'(sb.size()));
            check("ib_req", 32'(ib_req), 32'(exp_req));
            check("ib_addr", ib_addr, exp_pc);

            if (valid && ready && !jmp && sb.size() != 0) begin
                e = sb.pop_front();
                check("instr", instr, e.data);
                check("instr_addr", instr_addr, e.addr);
                check("instr_err", 32'(instr_err), 32'(e.err));
                cons_addr.push_back(instr_addr);
                cons_err.push_back(instr_err);
                n_cons++;
            end

            if (ib_rsp_valid && bq.size() != 0) begin
                b = bq.pop_front();
                if (!jmp && b.epoch == epoch) begin
                    sb.push_back('{addr: b.addr, data: b.data, err: b.err});
                    if (b.err) halted_m = 1'b1;
                end
            end

            if (ib_req && ib_req_ready) begin
                b.addr  = exp_pc;
                b.data  = $urandom;
                b.err   = err_rand ? ($urandom_range(0, 19) == 0)
                                   : (err_addr_en && exp_pc == err_addr);
                b.epoch = epoch;
                b.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
                bq.push_back(b);
                exp_pc = exp_pc + 32'd4;
                n_acc++;
            end

            if (jmp) begin
                sb.delete();
                epoch++;
                halted_m = 1'b0;
                exp_pc = jmp_addr & ~32'h3;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Asserts reset mid-cycle, checks the reset outputs, and releases it.
    task automatic do_reset();
        rst          = 1'b1;
        ready        = 1'b0;
        jmp          = 1'b0;
        ib_req_ready = 1'b0;
        bq.delete();
        sb.delete();
        exp_pc   = RST_A;
        halted_m = 1'b0;
        #1;
        check("rst valid", 32'(valid), 32'h0);
        check("rst level", 32'(level), 32'h0);
        check("rst ib_req", 32'(ib_req), 32'h0);
        check("rst ib_addr", ib_addr, RST_A);
        step();
        step();
        rst = 1'b0;
        cons_addr.delete();
        cons_err.delete();
        n_acc  = 0;
        n_cons = 0;
    endtask

    task automatic jump_to(input logic [31:0] target);
        jmp      = 1'b1;
        jmp_addr = target;
        cons_addr.delete();
        cons_err.delete();
        step();
        jmp = 1'b0;
    endtask

    task automatic wait_log(input int n, input string name);
        int k;
        k = 0;
        while (cons_addr.size() < n && k < 200) begin
            step();
            k++;
        end
        check(name, 32'(cons_addr.size() >= n), 32'h1);
    endtask

    int  acc_snap;
    bit  found;

    initial begin
        rst = 1'b1; ready = 1'b0; jmp = 1'b0; jmp_addr = '0; ib_req_ready = 1'b0;
        ib_rsp_valid = 1'b0; ib_rsp_data = '0; ib_rsp_err = 1'b0;

        // Zero-wait stream: one word per cycle after a 2-cycle start.
        lat_lo = 1; lat_hi = 1;
        do_reset();
        ib_req_ready = 1'b1; ready = 1'b1;
        repeat (22) step();
        check("stream consumed", 32'(n_cons), 32'd20);
        check("stream first", log_addr(0), 32'h0);
        check("stream last", log_addr(19), 32'h4C);

        // Fill and stall with decode held off.
        do_reset();
        ib_req_ready = 1'b1;
        repeat (20) step();
        check("fill level", 32'(level), 32'd4);
        check("fill ib_req", 32'(ib_req), 32'h0);
        check("fill accepts", 32'(n_acc), 32'd4);
        check("fill pc", ib_addr, 32'h10);
        ready = 1'b1;
        wait_log(5, "drain count");
        for (int i = 0; i < 5; i++) check("drain order", log_addr(i), 32'(i * 4));

        // Jump with requests to 0x20 and 0x24 still in flight.
        lat_lo = 4; lat_hi = 4;
        do_reset();
        ib_req_ready = 1'b1; ready = 1'b1;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (bq.size() == 2 && bq[0].addr == 32'h20 && bq[1].addr == 32'h24 && !ib_rsp_valid)
                found = 1;
            else
                step();
        end
        check("jmp2 setup", 32'(found), 32'h1);
        jump_to(32'h103);
        wait_log(2, "jmp2 count");
        check("jmp2 first", log_addr(0), 32'h100);
        check("jmp2 second", log_addr(1), 32'h104);

        // Jump in the same cycle as a response with two pending.
        do_reset();
        ib_req_ready = 1'b1; ready = 1'b1;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (bq.size() == 2 && ib_rsp_valid) found = 1;
            else step();
        end
        check("jmp rsp setup", 32'(found), 32'h1);
        jump_to(32'h200);
        wait_log(1, "jmp rsp count");
        check("jmp rsp first", log_addr(0), 32'h200);

        // Bus error at 0x40 halts fetch until a jump.
        lat_lo = 1; lat_hi = 1;
        err_addr_en = 1; err_addr = 32'h40;
        do_reset();
        ib_req_ready = 1'b1; ready = 1'b1;
        wait_log(17, "err count");
        check("err addr", log_addr(16), 32'h40);
        check("err flag", 32'(log_err(16)), 32'h1);
        acc_snap = n_acc;
        repeat (30) step();
        check("err halted accepts", 32'(n_acc), 32'(acc_snap));
        check("err halted ib_req", 32'(ib_req), 32'h0);
        jump_to(32'h80);
        wait_log(1, "err resume count");
        check("err resume addr", log_addr(0), 32'h80);
        check("err resume flag", 32'(log_err(0)), 32'h0);
        err_addr_en = 0;

        // Asynchronous reset with two requests in flight.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        ib_req_ready = 1'b1; ready = 1'b1;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (bq.size() == 2) found = 1;
            else step();
        end
        check("reset burst setup", 32'(found), 32'h1);
        do_reset();
        ib_req_ready = 1'b1; ready = 1'b1;
        wait_log(1, "reset restart count");
        check("reset restart addr", log_addr(0), RST_A);

        // Randomized traffic: latency, backpressure, jumps and bus errors.
        lat_lo = 1; lat_hi = 4; err_rand = 1;
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            ib_req_ready = ($urandom_range(0, 99) < 70);
            ready        = ($urandom_range(0, 99) < 60);
            jmp          = ($urandom_range(0, 99) < 6);
            jmp_addr     = $urandom;
            step();
        end
        jmp = 1'b0;
        check("random traffic delivered", 32'(n_cons > 100), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the instruction fetch stage; sits between the instruction bus and decode.
- Issues pipelined, in-order instruction reads with up to MAX_OUTSTANDING requests in flight.
- Buffers returned words in a DEPTH-entry FIFO tagged with address and bus-error status.
- Flushes on jmp, discards stale in-flight responses by count, and halts fetching after a bus error until the next jmp.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered bus requests; 1..DEPTH.
- RESET_ADDR, 32'h0, pc value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ib_addr  out  32  request address (= pc).
- ib_req  out  1  request valid.
- ib_req_ready  in  1  bus accepts request.
- ib_rsp_valid  in  1  response valid; in order, earliest 1 cycle after acceptance, no backpressure.
- ib_rsp_data  in  32  response word.
- ib_rsp_err  in  1  bus error for this response.
- instr  out  32  head instruction.
- instr_addr  out  32  head address.
- instr_err  out  1  head carries bus error.
- valid  out  1  FIFO not empty.
- ready  in  1  decode consumes head.
- jmp  in  1  redirect; flush.
- jmp_addr  in  32  target; bits [1:0] forced to 0.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async): pc=RESET_ADDR, FIFO empty, pending=0, drop=0, halted=0. Outputs: valid=0, level=0, ib_req=0, ib_addr=RESET_ADDR.
- Credit rule: ib_req = !rst && !jmp && !halted && (pending < MAX_OUTSTANDING) && (level + pending - drop < DEPTH).
  - Effect: every live response always has a free slot, so there is no overflow path.
- Request accept (ib_req && ib_req_ready):
  - pc += 4.
  - pc pushed into the address-tag FIFO (MAX_OUTSTANDING deep).
  - pending += 1.
- Response (ib_rsp_valid), in all cases: pending -= 1; the tag FIFO is popped.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise: write {data, tag, err} at wp; wp wraps mod DEPTH.
  - If err was written: halted = 1.
- Consume (valid && ready): rp advances, wrapping mod DEPTH.
- Level update: same-cycle write and consume leaves level unchanged; write alone +1; consume alone -1.
- Head latency: head visible on instr/valid the cycle after the response. Best-case round trip is request, then response, then valid: 2 cycles.
- jmp, which has priority over all other updates in its cycle:
  - pc = {jmp_addr[31:2], 2'b00}.
  - FIFO emptied (rp = wp, level = 0). A consume in the same cycle is ignored.
  - halted = 0.
  - drop = pending - (ib_rsp_valid ? 1 : 0). This counts every still-unanswered old request, including ones already marked for drop.
  - A response arriving in the jmp cycle is discarded.
  - ib_req = 0 in the jmp cycle, so no request is accepted with the stale pc.
- After jmp: new requests may issue immediately (next cycle) while drops are outstanding. Ordering guarantees stale responses arrive first.
- Back-to-back jmp: each recomputes drop from the current pending. The last target wins.
- Bus errors:
  - An error entry is delivered normally, with instr_err = 1.
  - Entries behind it are only those already in flight; they are delivered too.
  - No new requests are issued until jmp.
- Widths: pc wraps modulo 2^32. Pointers are $clog2(DEPTH) bits.

Test Plan:
- Zero-wait stream: after reset, bus with ready=1 and 1-cycle response latency, decode ready=1 -> instr_addr sequence 0,4,8,... with one word per cycle sustained after a 2-cycle start.
- Fill/stall: decode ready=0, DEPTH=4 -> exactly 4 requests accepted (0..C); ib_req stays 0; level=4. Then ready=1 -> words delivered in order, and fetch resumes at 0x10.
- Jump with 2 in flight (requests to 0x20 and 0x24 pending): jmp to 0x103 -> the two stale responses are dropped; next delivered instr_addr=0x100, then 0x104.
- Jump coincident with response: jmp in the same cycle as ib_rsp_valid, pending=2 -> drop=1; only one further response is discarded; valid stays 0 until a new-target word arrives.
- Bus error at 0x40 -> instr_err=1 at head with instr_addr=0x40; ib_req stays 0 indefinitely. jmp to 0x80 -> fetch resumes, and 0x80 is delivered with instr_err=0.
- Async reset asserted mid-burst with pending=2 -> valid=0, level=0 and ib_req=0 immediately. After release, fetch restarts at RESET_ADDR and no stale response is written.
